// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, muldiv op encodings, state enum and negation helpers
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MULDIV_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_RUN  = 2'd1,
        MULDIV_FIX  = 2'd2
    } muldiv_state_e;

    // Two's-complement negation of a data word.
    function automatic logic [XLEN-1:0] neg_xlen(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    // Two's-complement negation of a double-width product.
    function automatic logic [2*XLEN-1:0] neg_dxlen(input logic [2*XLEN-1:0] v);
        return ~v + (2*XLEN)'(1);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - issue/HI-LO access bundle between EX stage and the muldiv unit
interface muldiv_sequencer_if;
    import cpu_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            mf_req;
    logic            wr_hi;
    logic            wr_lo;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, a, b, flush, mf_req, wr_hi, wr_lo, wdata,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, mf_req, wr_hi, wr_lo, wdata,
        output busy, stall, done, hi, lo
    );

endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - 32-iteration MIPS mult/multu/div/divu unit owning HI/LO
module muldiv_sequencer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);

    muldiv_state_e   state_q, state_d;
    logic            is_div_q, is_div_d;
    logic            sign_q, sign_d;          // product / quotient sign
    logic            rem_sign_q, rem_sign_d;  // remainder follows the dividend
    logic            dbz_q, dbz_d;            // divide by zero
    logic [4:0]      count_q, count_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;      // product high half / remainder
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;      // multiplier bits / quotient
    logic [XLEN-1:0] opnd_q, opnd_d;          // multiplicand / divisor magnitude
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            signed_op;
    logic            op_is_div;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic              div_take;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    // Operand conditioning at issue: signed ops iterate on magnitudes.
    always_comb begin
        signed_op = (bus.op == MULDIV_MULT) || (bus.op == MULDIV_DIV);
        op_is_div = (bus.op == MULDIV_DIV) || (bus.op == MULDIV_DIVU);
        a_abs     = (signed_op && bus.a[XLEN-1]) ? neg_xlen(bus.a) : bus.a;
        b_abs     = (signed_op && bus.b[XLEN-1]) ? neg_xlen(bus.b) : bus.b;
    end

    // One shift-add / restoring-divide step, plus the sign fix-up values used in FIX.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        // A shifted remainder with bit 32 set always exceeds any 32-bit divisor.
        div_take  = div_shift[XLEN] | ~div_trial[XLEN];
        prod_mag  = {acc_hi_q, acc_lo_q};
        prod_fix  = sign_q ? neg_dxlen(prod_mag) : prod_mag;
        quo_fix   = sign_q ? neg_xlen(acc_lo_q) : acc_lo_q;
        rem_fix   = rem_sign_q ? neg_xlen(acc_hi_q) : acc_hi_q;
    end

    // Next-state logic for the IDLE/RUN/FIX sequencer and the HI/LO registers.
    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        sign_d     = sign_q;
        rem_sign_d = rem_sign_q;
        dbz_d      = dbz_q;
        count_d    = count_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            MULDIV_IDLE: begin
                if (bus.wr_hi) hi_d = bus.wdata;
                if (bus.wr_lo) lo_d = bus.wdata;
                if (bus.start && !bus.flush) begin
                    is_div_d   = op_is_div;
                    sign_d     = signed_op & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                    rem_sign_d = signed_op & bus.a[XLEN-1];
                    dbz_d      = op_is_div & (bus.b == '0);
                    count_d    = 5'd0;
                    acc_hi_d   = '0;
                    acc_lo_d   = op_is_div ? a_abs : b_abs;
                    opnd_d     = op_is_div ? b_abs : a_abs;
                    state_d    = MULDIV_RUN;
                end
            end
            MULDIV_RUN: begin
                if (is_div_q) begin
                    acc_hi_d = div_take ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
                    acc_lo_d = {acc_lo_q[XLEN-2:0], div_take};
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[XLEN-1:1]};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = MULDIV_FIX;
                if (bus.flush) state_d = MULDIV_IDLE;
            end
            MULDIV_FIX: begin
                if (bus.flush) begin
                    state_d = MULDIV_IDLE;
                end else begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = dbz_q ? {XLEN{1'b1}} : quo_fix;
                    end else begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = MULDIV_IDLE;
                end
            end
            default: state_d = MULDIV_IDLE;
        endcase

        busy_d = (state_d != MULDIV_IDLE);
    end

    // State and output registers; reset also clears HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= MULDIV_IDLE;
            is_div_q   <= 1'b0;
            sign_q     <= 1'b0;
            rem_sign_q <= 1'b0;
            dbz_q      <= 1'b0;
            count_q    <= 5'd0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            sign_q     <= sign_d;
            rem_sign_q <= rem_sign_d;
            dbz_q      <= dbz_d;
            count_q    <= count_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.stall = busy_q & (bus.start | bus.mf_req | bus.wr_hi | bus.wr_lo);

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit for the pipelined CPU. It executes MIPS mult, multu, div and divu over 32 iterations and owns the architectural HI/LO registers. It sits beside the EX-stage ALU and stalls the pipeline only when a younger instruction needs HI/LO or the unit itself while an operation is in flight. mthi/mtlo writes and mfhi/mflo reads go through this block.

## Interface
- No parameters. Datapath width is fixed at 32 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  issue an operation from EX; sampled only in IDLE
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu
- a  in  32  multiplicand / dividend (rs)
- b  in  32  multiplier / divisor (rt)
- flush  in  1  abort the in-flight operation (branch/exception squash)
- mf_req  in  1  a decode-stage mfhi/mflo needs HI/LO
- wr_hi, wr_lo  in  1  mthi/mtlo strobes
- wdata  in  32  mthi/mtlo data
- busy  out  1  operation in flight
- stall  out  1  `busy & (start | mf_req | wr_hi | wr_lo)`, combinational
- done  out  1  one-cycle pulse when HI/LO have been updated
- hi, lo  out  32  HI/LO register contents

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE**
  - start=1: latch op, then |a| and |b| (signed ops) or raw a, b (unsigned ops).
  - Record the result signs:
    - product sign = a[31]^b[31];
    - quotient sign = a[31]^b[31];
    - remainder sign = a[31].
  - Clear the 5-bit count and go to RUN.
- **RUN, multiply:** shift-add on a 64-bit accumulator {acc_hi, acc_lo}, with acc_lo initialised to the multiplier.
  - Each cycle: if acc_lo[0]=1, add the multiplicand to acc_hi with a 33-bit carry.
  - Then shift the 65-bit {carry, acc_hi, acc_lo} right by 1.
- **RUN, divide:** restoring division.
  - Each cycle: shift {rem, quo} left by 1 and compute trial = rem − divisor in 33 bits.
  - If trial is non-negative, set rem = trial and quo[0] = 1.
- **RUN exit:** after count=31, go to FIX.
- **FIX** (single cycle):
  - Apply two's-complement negation where the recorded sign requires it.
  - Write HI/LO: product gives HI=upper 32 bits, LO=lower 32 bits; divide gives LO=quotient, HI=remainder.
  - Go to IDLE and pulse done on the following cycle.
- **Divide by zero** (b=0, div or divu): LO=FFFFFFFF and HI=a, regardless of sign.
- **Signed overflow** (div 80000000/FFFFFFFF): LO=80000000, HI=00000000. This falls naturally out of the abs/negate path.
- **mthi/mtlo in IDLE:** write HI/LO on the next edge. If start and wr_* are asserted together in IDLE, the write lands first, but the start operation's FIX overwrites both registers.
- **While busy:** start, wr_hi, wr_lo and mf_req are not acted on. stall is raised, and the pipeline holds the instruction until busy falls.
- **flush while busy:** return to IDLE on the next edge. HI/LO are unchanged and no done pulse is produced. flush in IDLE has no effect, and a start in the same cycle is dropped.
- **hi/lo outputs:** register values; a new result is visible the cycle after FIX.

## Timing
- **Reset values:** state=IDLE, busy=0, done=0, hi=0, lo=0, count=0. stall=0 follows from busy=0.
- **Reset mid-operation:** aborts immediately and also clears HI/LO.
- **Cycle-level sequence** for a start sampled in cycle T:
  - busy=1 in cycles T+1..T+33 (RUN T+1..T+32, FIX T+33);
  - HI/LO valid and done=1 in T+34;
  - busy=0 in T+34, so a back-to-back start is accepted in T+34.
- **Total latency:** 34 cycles from start to a usable result. The mfhi waiting on stall issues in T+34.
- **Output timing:** stall is combinational from registered busy, so there is no loop through start. All other outputs are registered.

## Structure
- **Shared package cpu_pkg:**
  - MULDIV_MULT/MULTU/DIV/DIVU op encodings, matching the 2-bit op port;
  - the muldiv state enum (IDLE/RUN/FIX);
  - the XLEN=32 constant.
- **Single module:** the iteration step is inline and no sub-module is required. The negation helper is a function in cpu_pkg.

## Test plan
- **Reset mid-run:** reset, then mthi 12345678 and mtlo 9ABCDEF0, then mfhi/mflo in IDLE → hi=12345678, lo=9ABCDEF0, stall=0. Start mult and pull rst_n low at T+10 → state IDLE, hi=lo=0 and no done.
- **mult:** mult a=FFFFFFFD (−3), b=5 → done at T+34, HI=FFFFFFFF, LO=FFFFFFF1. busy is high exactly T+1..T+33.
- **multu with back-to-back start:** multu FFFFFFFF×FFFFFFFF → HI=FFFFFFFE, LO=00000001. A second start held at T+5 sees stall=1 and is accepted at T+34.
- **Signed divide:** div −7/2 → LO=FFFFFFFD, HI=FFFFFFFF. div 80000000/FFFFFFFF → LO=80000000, HI=0.
- **Divide by zero:** divu 1234/0 → LO=FFFFFFFF, HI=00001234. div −5/0 → LO=FFFFFFFF, HI=FFFFFFFB.
- **Flush:** flush at T+20 of a div → IDLE at T+21, HI/LO keep their prior values, done never pulses. mf_req during busy → stall=1 until T+34.
